// File: rtl/pan_lfo_scheduler.sv
// Time-multiplexed auto-pan LFO scheduler: one sine ROM port and one multiplier shared across NUM_CH channels.
// Latency: 3*NUM_CH+2 cycles from SAMPLE_TICK to PAN_VALID; each channel takes a fixed FETCH/WAIT/CALC slot.
// Backpressure: none; one tick may queue behind a running sweep, and further ticks are dropped with a TICK_MISS pulse.
module pan_lfo_scheduler #(
  parameter int NUM_CH = 4
) (
  input  logic                   CLOCK_50,
  input  logic                   RESET,
  input  logic                   SAMPLE_TICK,
  input  logic [NUM_CH-1:0]      AUTO_PAN_EN,
  input  logic [16*NUM_CH-1:0]   PAN_RATE,
  input  logic [16*NUM_CH-1:0]   PAN_DEPTH,
  output logic [11:0]            ROM_ADDR,
  output logic                   ROM_CS,
  input  logic [15:0]            ROM_DATA,
  output logic [16*NUM_CH-1:0]   PAN_OUT,
  output logic                   PAN_VALID,
  output logic                   BUSY,
  output logic                   TICK_MISS
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_CALC, S_DONE} state_t;

  state_t              state_q;
  logic [CH_W-1:0]     ch_q;
  logic                pending_q;
  logic [23:0]         phase_q  [NUM_CH];
  logic [15:0]         shadow_q [NUM_CH];
  logic [16*NUM_CH-1:0] pan_q;
  logic                en_q;
  logic signed [15:0]  depth_q;
  logic signed [15:0]  rom_q;
  logic [11:0]         rom_addr_q;
  logic                valid_q;
  logic                miss_q;

  logic [15:0]         rate_a  [NUM_CH];
  logic [15:0]         depth_a [NUM_CH];
  logic                cur_en;
  logic signed [31:0]  prod;
  logic signed [31:0]  val;
  logic [15:0]         calc_res;

  // Unpack the per-channel rate/depth buses so the active channel can be selected by index
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      rate_a[i]  = PAN_RATE[16*i +: 16];
      depth_a[i] = PAN_DEPTH[16*i +: 16];
    end
  end

  // ROM port is driven during FETCH only; the address holds its last value otherwise
  assign cur_en   = AUTO_PAN_EN[ch_q];
  assign ROM_CS   = (state_q == S_FETCH) && cur_en;
  assign ROM_ADDR = ROM_CS ? phase_q[ch_q][23:12] : rom_addr_q;

  // Pan position: centre plus floor(depth*sine/65536), clamped to the 15-bit positive range
  always_comb begin
    prod     = depth_q * rom_q;
    val      = 32'sh0000_4000 + (prod >>> 16);
    calc_res = val[15:0];
    if (val < 0)
      calc_res = 16'h0000;
    else if (val > 32'sh0000_7FFF)
      calc_res = 16'h7FFF;
  end

  assign PAN_OUT   = pan_q;
  assign PAN_VALID = valid_q;
  assign TICK_MISS = miss_q;
  assign BUSY      = (state_q != S_IDLE);

  // Sweep sequencer: per-channel FETCH/WAIT/CALC slots, tick queueing and the all-channel commit
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      pending_q  <= 1'b0;
      en_q       <= 1'b0;
      depth_q    <= '0;
      rom_q      <= '0;
      rom_addr_q <= '0;
      valid_q    <= 1'b0;
      miss_q     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        phase_q[i]          <= '0;
        shadow_q[i]         <= 16'h4000;
        pan_q[16*i +: 16]   <= 16'h4000;
      end
    end else begin
      valid_q <= 1'b0;
      miss_q  <= 1'b0;
      // DONE handles its own tick below so a tick there is never lost
      if (SAMPLE_TICK && state_q != S_IDLE && state_q != S_DONE) begin
        if (pending_q) miss_q    <= 1'b1;
        else           pending_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (SAMPLE_TICK) begin
            ch_q    <= '0;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          en_q    <= cur_en;
          depth_q <= depth_a[ch_q];
          if (cur_en) begin
            rom_addr_q    <= phase_q[ch_q][23:12];
            phase_q[ch_q] <= phase_q[ch_q] + {8'h00, rate_a[ch_q]};
          end else begin
            phase_q[ch_q] <= '0;
          end
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          rom_q   <= ROM_DATA;
          state_q <= S_CALC;
        end
        S_CALC: begin
          shadow_q[ch_q] <= en_q ? calc_res : 16'h4000;
          if (ch_q == LAST_CH) begin
            state_q <= S_DONE;
          end else begin
            ch_q    <= ch_q + 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_DONE: begin
          for (int i = 0; i < NUM_CH; i++) pan_q[16*i +: 16] <= shadow_q[i];
          valid_q <= 1'b1;
          if (pending_q || SAMPLE_TICK) begin
            pending_q <= pending_q && SAMPLE_TICK;
            ch_q      <= '0;
            state_q   <= S_FETCH;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pan_lfo_scheduler.sv
// Directed bench for pan_lfo_scheduler with NUM_CH = 4 and a registered ROM model.
// Checks reset state, sweep latency, pan arithmetic, enables, tick queueing/drop and mid-sweep reset.
// The ROM returns its address as data, or a forced constant when rom_force is set.
module tb_pan_lfo_scheduler;

  logic        CLOCK_50 = 1'b0;
  logic        RESET = 1'b1;
  logic        SAMPLE_TICK = 1'b0;
  logic [3:0]  AUTO_PAN_EN = 4'hF;
  logic [63:0] PAN_RATE = {4{16'h1000}};
  logic [63:0] PAN_DEPTH = {4{16'h7FFF}};
  logic [11:0] ROM_ADDR;
  logic        ROM_CS;
  logic [15:0] ROM_DATA = 16'h0000;
  logic [63:0] PAN_OUT;
  logic        PAN_VALID;
  logic        BUSY;
  logic        TICK_MISS;

  logic        rom_force = 1'b0;
  logic [15:0] rom_force_val = 16'h0000;

  int n_assert = 0;
  int n_fail   = 0;

  pan_lfo_scheduler #(.NUM_CH(4)) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET      (RESET),
    .SAMPLE_TICK(SAMPLE_TICK),
    .AUTO_PAN_EN(AUTO_PAN_EN),
    .PAN_RATE   (PAN_RATE),
    .PAN_DEPTH  (PAN_DEPTH),
    .ROM_ADDR   (ROM_ADDR),
    .ROM_CS     (ROM_CS),
    .ROM_DATA   (ROM_DATA),
    .PAN_OUT    (PAN_OUT),
    .PAN_VALID  (PAN_VALID),
    .BUSY       (BUSY),
    .TICK_MISS  (TICK_MISS)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Registered sine ROM stand-in: data appears the cycle after chip select
  always @(posedge CLOCK_50) begin
    if (ROM_CS) ROM_DATA <= rom_force ? rom_force_val : {4'h0, ROM_ADDR};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Fire a tick, plus optional extra ticks raised after edges t2/t3, and observe win edges
  task automatic run(input int t2, input int t3, input int win,
                     output int pv1, output int pv2, output int pv_cnt, output int miss_cnt,
                     output logic [3:0] cs_slot, output int cs_cnt, output logic [47:0] addr_slot,
                     output logic early_change, output logic busy1, output logic busy_pv);
    logic [63:0] prev;
    pv1 = -1; pv2 = -1; pv_cnt = 0; miss_cnt = 0; cs_slot = '0; cs_cnt = 0;
    addr_slot = '0; early_change = 1'b0; busy1 = 1'b0; busy_pv = 1'b1;
    prev = PAN_OUT;
    @(posedge CLOCK_50); #1;
    SAMPLE_TICK = 1'b1;
    for (int n = 1; n <= win; n++) begin
      @(posedge CLOCK_50); #1;
      if (n == 1) busy1 = BUSY;
      for (int i = 0; i < 4; i++) begin
        if (n == 1 + 3*i) begin
          cs_slot[i] = ROM_CS;
          addr_slot[12*i +: 12] = ROM_ADDR;
        end
      end
      if (ROM_CS) cs_cnt++;
      if (PAN_VALID) begin
        pv_cnt++;
        if (pv1 < 0) begin
          pv1 = n;
          busy_pv = BUSY;
        end else if (pv2 < 0) begin
          pv2 = n;
        end
      end else if (pv1 < 0 && PAN_OUT !== prev) begin
        early_change = 1'b1;
      end
      if (TICK_MISS) miss_cnt++;
      SAMPLE_TICK = (n == t2) || (n == t3);
    end
    SAMPLE_TICK = 1'b0;
  endtask

  // One isolated sweep with full checking of latency, commit, ROM slots and BUSY
  task automatic sweep(input string tag, input logic [63:0] exp_pan, input logic [3:0] exp_cs,
                       input logic [47:0] exp_addr);
    int pv1, pv2, pv_cnt, miss_cnt, cs_cnt;
    logic [3:0] cs_slot;
    logic [47:0] addr_slot;
    logic early, b1, bpv;
    run(-1, -1, 16, pv1, pv2, pv_cnt, miss_cnt, cs_slot, cs_cnt, addr_slot, early, b1, bpv);
    chk({tag, "_latency"}, 64'(pv1), 64'd14);
    chk({tag, "_pv_count"}, 64'(pv_cnt), 64'd1);
    chk({tag, "_pan_out"}, PAN_OUT, exp_pan);
    chk({tag, "_cs_slots"}, {60'd0, cs_slot}, {60'd0, exp_cs});
    chk({tag, "_cs_total"}, 64'(cs_cnt), 64'($countones(exp_cs)));
    chk({tag, "_rom_addr"}, {16'd0, addr_slot}, {16'd0, exp_addr});
    chk({tag, "_no_partial"}, {63'd0, early}, 64'd0);
    chk({tag, "_busy_first"}, {63'd0, b1}, 64'd1);
    chk({tag, "_busy_at_valid"}, {63'd0, bpv}, 64'd0);
  endtask

  initial begin
    int pv1, pv2, pv_cnt, miss_cnt, cs_cnt, idle_pv;
    logic [3:0] cs_slot;
    logic [47:0] addr_slot;
    logic early, b1, bpv;

    // Reset and idle
    repeat (3) @(posedge CLOCK_50);
    #1 RESET = 1'b0;
    chk("rst_pan_out", PAN_OUT, {4{16'h4000}});
    chk("rst_busy", {63'd0, BUSY}, 64'd0);
    chk("rst_valid", {63'd0, PAN_VALID}, 64'd0);
    chk("rst_rom_cs", {63'd0, ROM_CS}, 64'd0);
    chk("rst_rom_addr", {52'd0, ROM_ADDR}, 64'd0);
    chk("rst_tick_miss", {63'd0, TICK_MISS}, 64'd0);
    idle_pv = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge CLOCK_50); #1;
      if (PAN_VALID) idle_pv++;
    end
    chk("idle_no_valid", 64'(idle_pv), 64'd0);
    chk("idle_busy", {63'd0, BUSY}, 64'd0);

    // Address-as-data ROM, depth 0x7FFF: small sine values stay at centre
    sweep("s1_addr0", {4{16'h4000}}, 4'hF, {4{12'h000}});
    sweep("s2_addr1", {4{16'h4000}}, 4'hF, {4{12'h001}});

    // Full-scale ROM values
    rom_force = 1'b1;
    rom_force_val = 16'h7FFF;
    sweep("s3_pos_full", {4{16'h7FFF}}, 4'hF, {4{12'h002}});
    rom_force_val = 16'h8000;
    sweep("s4_neg_full", {4{16'h0000}}, 4'hF, {4{12'h003}});

    // Per-channel depths with ROM = -32768: ch0 half, ch1 zero, ch2 max, ch3 min (saturates)
    PAN_DEPTH = {16'h8000, 16'h7FFF, 16'h0000, 16'h4000};
    sweep("s5_depth_mix", {16'h7FFF, 16'h0000, 16'h4000, 16'h2000}, 4'hF, {4{12'h004}});

    // Floor rounding of a tiny negative product
    PAN_DEPTH = {4{16'hFFFF}};
    rom_force_val = 16'h0001;
    sweep("s6_floor", {4{16'h3FFF}}, 4'hF, {4{12'h005}});

    // Channels 1 and 3 disabled: no chip select, centre output, address holds
    PAN_DEPTH = {4{16'h7FFF}};
    rom_force_val = 16'h7FFF;
    AUTO_PAN_EN = 4'b0101;
    sweep("s7_en_0101", {16'h4000, 16'h7FFF, 16'h4000, 16'h7FFF}, 4'b0101, {4{12'h006}});

    // Re-enabled channels restart from phase 0
    AUTO_PAN_EN = 4'hF;
    sweep("s8_reenable", {4{16'h7FFF}}, 4'hF, {12'h000, 12'h007, 12'h000, 12'h007});

    // Tick during a sweep queues a back-to-back sweep
    run(5, -1, 32, pv1, pv2, pv_cnt, miss_cnt, cs_slot, cs_cnt, addr_slot, early, b1, bpv);
    chk("ovl_pv1", 64'(pv1), 64'd14);
    chk("ovl_pv2", 64'(pv2), 64'd27);
    chk("ovl_pv_count", 64'(pv_cnt), 64'd2);
    chk("ovl_miss", 64'(miss_cnt), 64'd0);

    // Third tick while pending is dropped
    run(5, 8, 32, pv1, pv2, pv_cnt, miss_cnt, cs_slot, cs_cnt, addr_slot, early, b1, bpv);
    chk("drop_pv_count", 64'(pv_cnt), 64'd2);
    chk("drop_pv2", 64'(pv2), 64'd27);
    chk("drop_miss", 64'(miss_cnt), 64'd1);

    // Reset in the middle of a sweep
    @(posedge CLOCK_50); #1 SAMPLE_TICK = 1'b1;
    @(posedge CLOCK_50); #1 SAMPLE_TICK = 1'b0;
    repeat (4) @(posedge CLOCK_50);
    #1;
    chk("mid_pan_before_rst", PAN_OUT, {4{16'h7FFF}});
    chk("mid_busy_before_rst", {63'd0, BUSY}, 64'd1);
    RESET = 1'b1;
    @(posedge CLOCK_50); #1 RESET = 1'b0;
    chk("mid_rst_pan_out", PAN_OUT, {4{16'h4000}});
    chk("mid_rst_busy", {63'd0, BUSY}, 64'd0);
    chk("mid_rst_rom_addr", {52'd0, ROM_ADDR}, 64'd0);
    idle_pv = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge CLOCK_50); #1;
      if (PAN_VALID) idle_pv++;
    end
    chk("mid_rst_no_valid", 64'(idle_pv), 64'd0);
    chk("mid_rst_pan_hold", PAN_OUT, {4{16'h4000}});

    // First sweep after reset starts from phase 0
    rom_force = 1'b0;
    sweep("s9_after_rst", {4{16'h4000}}, 4'hF, {4{12'h000}});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pan_lfo_scheduler.md
# pan_lfo_scheduler

Time-multiplexed auto-pan controller that shares one sine ROM port and one 16x16 signed multiplier among NUM_CH panner channels. Each SAMPLE_TICK starts one fixed-schedule sweep. The sweep advances every channel's LFO phase accumulator, fetches that channel's sine sample, and computes its pan position. All channel outputs then commit together at the end of the sweep. It replaces one Autopanner instance per voice in the mixer path; PAN_OUT feeds the left/right gain stage.

## Interface
- NUM_CH, 4: number of panner channels (1..16).
- CLOCK_50  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- SAMPLE_TICK  in  1  one-cycle pulse at audio sample rate; starts a sweep.
- AUTO_PAN_EN  in  NUM_CH  per-channel enable; bit i = channel i.
- PAN_RATE  in  16*NUM_CH  per-channel phase increment, unsigned; channel i = [16i+15:16i].
- PAN_DEPTH  in  16*NUM_CH  per-channel depth, signed two's complement.
- ROM_ADDR  out  12  shared sine ROM address (4096-entry, signed 16-bit table).
- ROM_CS  out  1  ROM chip select; high only in FETCH.
- ROM_DATA  in  16  ROM output, signed; valid the cycle after ROM_CS (registered ROM, latency 1).
- PAN_OUT  out  16*NUM_CH  committed pan positions: 0x0000 = hard left, 0x4000 = centre, 0x7FFF = hard right.
- PAN_VALID  out  1  one-cycle pulse when PAN_OUT has just been updated.
- BUSY  out  1  high while a sweep is in progress.
- TICK_MISS  out  1  one-cycle pulse when a tick is dropped.

## Operation
- Per-channel state: 24-bit phase accumulator phase[i]. ROM address = phase[i][23:12]. Per-channel 16-bit shadow register shadow[i].
- FSM states: IDLE, FETCH, WAIT, CALC, DONE. Channel index ch counts 0..NUM_CH-1.
- IDLE: when SAMPLE_TICK = 1, set ch = 0 and go to FETCH.
- FETCH (channel ch): sample AUTO_PAN_EN[ch] and PAN_DEPTH[ch] into holding registers.
  - If enabled: ROM_ADDR = phase[ch][23:12] (pre-increment phase), ROM_CS = 1, and phase[ch] <= phase[ch] + {8'h00, PAN_RATE[ch]}, mod 2^24 (wraps silently).
  - If disabled: ROM_CS = 0, phase[ch] <= 0, ROM_ADDR holds its previous value.
  - Next state: WAIT.
- WAIT: ROM latency cycle; nothing is computed. Next state: CALC.
- CALC: compute the result into shadow[ch].
  - If enabled: prod = signed(depth) * signed(ROM_DATA), 32-bit. off = prod >>> 16 (arithmetic shift, floor). val = 0x4000 + off, evaluated at 17 bits signed. Saturate val to [0x0000, 0x7FFF]. shadow[ch] <= val.
  - If disabled: shadow[ch] <= 0x4000.
  - If ch = NUM_CH-1, go to DONE; otherwise ch += 1 and go to FETCH.
- DONE: PAN_OUT <= all shadow[] simultaneously; PAN_VALID <= 1 (pulse). Then:
  - if pending = 1: clear pending, set ch = 0, go to FETCH;
  - otherwise go to IDLE.
- Tick handling outside IDLE (FETCH/WAIT/CALC/DONE):
  - SAMPLE_TICK sets the one-deep pending flag.
  - A tick arriving while pending is already 1 is dropped and TICK_MISS pulses the next cycle.
  - A tick in IDLE never sets pending.
- Disabled channels keep the same 3-cycle slot, so the schedule length is fixed regardless of enables.
- Partial sweeps are never visible: PAN_OUT changes only on the DONE commit.

## Timing
- Reset values:
  - state IDLE, ch 0, pending 0;
  - all phase[] = 0, all shadow[] = 0x4000, all PAN_OUT = 0x4000;
  - ROM_ADDR 0, ROM_CS 0, PAN_VALID 0, BUSY 0, TICK_MISS 0.
- RESET in any state, including mid-sweep, takes effect at the next edge. It aborts the sweep and discards shadow contents; PAN_OUT returns to 0x4000. RESET overrides a simultaneous SAMPLE_TICK.
- Sweep timing, with the tick sampled at edge k:
  - channel i occupies FETCH/WAIT/CALC in cycles k+1+3i, k+2+3i and k+3+3i;
  - DONE is cycle k+3N+1;
  - PAN_OUT updates and PAN_VALID is high in cycle k+3N+2;
  - latency is therefore 3N+2 cycles (14 for N=4).
- BUSY is high from the first FETCH through DONE inclusive.
- Back-to-back sweeps: with pending set, FETCH ch0 directly follows DONE, with no IDLE cycle. Minimum sweep period is 3N+1 cycles.
- The ROM_DATA used in CALC is the value present in the cycle after that channel's FETCH.

## Test plan
- Reset, then no ticks: all PAN_OUT = 0x4000, BUSY = 0, PAN_VALID never asserts.
- N=4, all channels enabled, RATE = 0x1000 on every channel, DEPTH = 0x7FFF, ROM model returns its address as data:
  - tick 1 reads address 0x000 → PAN_OUT = 0x4000; tick 2 reads 0x001 → 0x4000 + floor(0x7FFF*1/65536) = 0x4000;
  - separately, set ROM_DATA = 0x7FFF → 0x7FFF; ROM_DATA = 0x8000 → 0x0000;
  - PAN_VALID lands exactly 14 cycles after the tick.
- Saturation: DEPTH = 0x8000 with ROM_DATA = 0x8000 → PAN_OUT = 0x7FFF, not 0x8000.
- Enable toggling: AUTO_PAN_EN = 4'b0101 → channels 1 and 3 show 0x4000 and never assert ROM_CS in their FETCH slots. Then re-enable channel 1 → its first fetch is at ROM_ADDR 0x000.
- Overlapping ticks:
  - tick during the sweep → the second sweep starts immediately after DONE (PAN_VALID pulses 13 cycles apart);
  - a third tick while pending → one TICK_MISS pulse and only two PAN_VALID pulses.
- Reset asserted in cycle k+6 of a sweep → PAN_OUT stays 0x4000, no PAN_VALID pulse, phase[] cleared, and the next tick behaves as the first after reset.
